// File: rtl/agc_serial_ctrl_if.sv
// agc_serial_ctrl_if: backend serial config pins, ADC sample stream and host force request for agc_serial_ctrl
interface agc_serial_ctrl_if;
   logic       i_ready;
   logic       i_adc_valid;
   logic [3:0] i_adc;
   logic       i_force_valid;
   logic [2:0] i_force_gain;
   logic       o_sclk;
   logic       o_sdin;
   logic       o_busy;
   logic [2:0] o_gain;
   logic       o_sat_hi;
   logic       o_sat_lo;
   modport master (
      input  i_ready, i_adc_valid, i_adc, i_force_valid, i_force_gain,
      output o_sclk, o_sdin, o_busy, o_gain, o_sat_hi, o_sat_lo
   );
   modport slave (
      output i_ready, i_adc_valid, i_adc, i_force_valid, i_force_gain,
      input  o_sclk, o_sdin, o_busy, o_gain, o_sat_hi, o_sat_lo
   );
endinterface

// File: rtl/agc_serial_ctrl.sv
// agc_serial_ctrl: windowed-average AGC programming amplifier gain over sclk/sdin; define AGC_FORCE_EN to enable host force-gain
module agc_serial_ctrl #(
   parameter int         SCLK_DIV  = 4,
   parameter int         WIN_LOG2  = 3,
   parameter int         HI_TH     = 12,
   parameter int         LO_TH     = 6,
   parameter int         HOLD      = 16,
   parameter logic [2:0] INIT_GAIN = 3'd4
) (
   input logic               i_clk,
   input logic               i_reset,
   agc_serial_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, SHIFT, SETTLE, ACCUM, DECIDE} state_t;
   localparam int WIN = 1 << WIN_LOG2;
   localparam int SW  = $clog2((HOLD > WIN ? HOLD : WIN) + 1);
   localparam int DW  = $clog2(SCLK_DIV + 1);
   localparam int AW  = 4 + WIN_LOG2;
   state_t        state, next;
   logic [2:0]    tgt, gain, bcnt;
   logic [DW-1:0] dcnt;
   logic [SW-1:0] scnt;
   logic [AW-1:0] acc;
   logic [3:0]    avg;
   logic [4:0]    frame;
   logic          ph, sat_hi, sat_lo, half_end, force_ok, frame_done, hold_done, win_done, dec_dn, dec_up;
`ifdef AGC_FORCE_EN
   assign force_ok = bus.i_force_valid && (state == SETTLE || state == ACCUM || state == DECIDE);
`else
   logic unused_force;
   assign unused_force = bus.i_force_valid;
   assign force_ok = 1'b0;
`endif
   assign avg        = acc[AW-1:WIN_LOG2];
   assign dec_dn     = avg > 4'(HI_TH) && gain != 3'd0;
   assign dec_up     = avg < 4'(LO_TH) && gain != 3'd7;
   assign half_end   = dcnt == DW'(SCLK_DIV - 1);
   assign frame_done = state == SHIFT && ph && half_end && bcnt == 3'd4;
   assign hold_done  = bus.i_adc_valid && scnt == SW'(HOLD - 1);
   assign win_done   = bus.i_adc_valid && scnt == SW'(WIN - 1);
   assign frame      = {tgt, 2'b00};
   // state register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else state <= next;
   end
   // next state: ready loss wins, then a host force, then the normal flow
   always_comb begin
      next = state;
      if (!bus.i_ready) next = IDLE;
      else if (force_ok) next = SHIFT;
      else begin
         case (state)
            IDLE:    next = SHIFT;
            SHIFT:   next = frame_done ? SETTLE : SHIFT;
            SETTLE:  next = hold_done ? ACCUM : SETTLE;
            ACCUM:   next = win_done ? DECIDE : ACCUM;
            DECIDE:  next = (dec_dn || dec_up) ? SHIFT : ACCUM;
            default: next = IDLE;
         endcase
      end
   end
   // datapath: bit timing, sample counting and summing, gain target, committed gain and saturation flags
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         dcnt   <= '0;
         ph     <= 1'b0;
         bcnt   <= 3'd0;
         scnt   <= '0;
         acc    <= '0;
         tgt    <= INIT_GAIN;
         gain   <= INIT_GAIN;
         sat_hi <= 1'b0;
         sat_lo <= 1'b0;
      end else begin
         dcnt <= (state != SHIFT || half_end) ? '0 : dcnt + 1'b1;
         ph   <= state == SHIFT && (half_end ? !ph : ph);
         bcnt <= state != SHIFT ? 3'd0 : (ph && half_end) ? bcnt + 1'b1 : bcnt;
         scnt <= next != state ? '0 : (bus.i_adc_valid && (state == SETTLE || state == ACCUM)) ? scnt + 1'b1 : scnt;
         acc  <= (next == ACCUM && state != ACCUM) ? '0 : (state == ACCUM && bus.i_adc_valid) ? acc + AW'(bus.i_adc) : acc;
         if (force_ok) tgt <= bus.i_force_gain;
         else if (state == IDLE) tgt <= INIT_GAIN;
         else if (state == DECIDE && (dec_dn || dec_up)) tgt <= dec_dn ? gain - 3'd1 : gain + 3'd1;
         if (frame_done && bus.i_ready) gain <= tgt;
         if (state == DECIDE && bus.i_ready && !force_ok) begin
            sat_hi <= avg > 4'(HI_TH) && gain == 3'd0;
            sat_lo <= avg < 4'(LO_TH) && gain == 3'd7;
         end
      end
   end
   // outputs: serial pins are only active while shifting, so an abort or reset parks them low
   always_comb begin
      bus.o_busy   = state == SHIFT;
      bus.o_sclk   = state == SHIFT && ph;
      bus.o_sdin   = state == SHIFT && frame[3'd4 - bcnt];
      bus.o_gain   = gain;
      bus.o_sat_hi = sat_hi;
      bus.o_sat_lo = sat_lo;
   end
endmodule

// File: tb/tb_agc_serial_ctrl.sv
// tb_agc_serial_ctrl: self-checking bench for agc_serial_ctrl at default parameters (frame decoder, vector table, random windows vs model)
module tb_agc_serial_ctrl;
   typedef struct {int val; int gain; int frame; int hi; int lo;} vec_t;
   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   int         checks = 0;
   int         failures = 0;
   int         viol = 0;
   int         nbits = 0;
   int         mg = 4;
   int         win[8];
   logic [4:0] shreg = '0;
   logic       sclk_q = 1'b0;
   logic       sdin_q = 1'b0;
   logic [4:0] frames[$];
   vec_t       tbl[19];
   agc_serial_ctrl_if bus();
   agc_serial_ctrl dut (.i_clk(i_clk), .i_reset(i_reset), .bus(bus));
   always #5 i_clk = ~i_clk;
   // decode frames from the pins: one data bit per sclk rise, partial frames dropped when busy falls
   always @(negedge i_clk) begin
      if (bus.o_sclk && !sclk_q) begin
         shreg = {shreg[3:0], bus.o_sdin};
         nbits++;
         if (nbits == 5) begin
            frames.push_back(shreg);
            nbits = 0;
         end
      end
      if (bus.o_sclk && sclk_q && bus.o_sdin != sdin_q) viol++;
      if (!bus.o_busy) nbits = 0;
      sclk_q = bus.o_sclk;
      sdin_q = bus.o_sdin;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask
   task automatic drive(input int from, input int to, input int gap);
      for (int i = from; i < to; i++) begin
         repeat ($urandom_range(0, gap)) tick();
         bus.i_adc_valid = 1'b1;
         bus.i_adc = 4'(win[i]);
         tick();
         bus.i_adc_valid = 1'b0;
      end
   endtask
   task automatic decide_cycle(input int junk);
      bus.i_adc_valid = junk != 0;
      bus.i_adc = 4'($urandom_range(0, 15));
      tick();
      bus.i_adc_valid = 1'b0;
   endtask
   task automatic settle();
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 1)) tick();
         bus.i_adc_valid = 1'b1;
         bus.i_adc = 4'($urandom_range(0, 15));
         tick();
         bus.i_adc_valid = 1'b0;
      end
   endtask
   task automatic expect_frame(input string nm, input int g, input int len);
      int n;
      n = 0;
      chk({nm, " busy"}, int'(bus.o_busy), 1);
      while (bus.o_busy && n < 200) begin
         bus.i_adc_valid = 1'($urandom_range(0, 1));
         bus.i_adc = 4'($urandom_range(0, 15));
         tick();
         n++;
      end
      bus.i_adc_valid = 1'b0;
      chk({nm, " frame cycles"}, n, len);
      chk({nm, " frames seen"}, frames.size(), 1);
      if (frames.size() != 0) chk({nm, " frame bits"}, int'(frames.pop_front()), g * 4);
      frames.delete();
      chk({nm, " gain"}, int'(bus.o_gain), g);
   endtask
   task automatic expect_none(input string nm, input int g);
      chk({nm, " busy"}, int'(bus.o_busy), 0);
      chk({nm, " frames seen"}, frames.size(), 0);
      chk({nm, " gain"}, int'(bus.o_gain), g);
   endtask
   initial begin
      bus.i_ready = 1'b0;
      bus.i_adc_valid = 1'b0;
      bus.i_adc = 4'd0;
      bus.i_force_valid = 1'b0;
      bus.i_force_gain = 3'd0;
      tbl = '{'{15, 3, 1, 0, 0}, '{9, 3, 0, 0, 0}, '{15, 2, 1, 0, 0}, '{15, 1, 1, 0, 0}, '{15, 0, 1, 0, 0},
              '{14, 0, 0, 1, 0}, '{9, 0, 0, 0, 0}, '{2, 1, 1, 0, 0}, '{2, 2, 1, 0, 0}, '{2, 3, 1, 0, 0},
              '{2, 4, 1, 0, 0}, '{2, 5, 1, 0, 0}, '{2, 6, 1, 0, 0}, '{2, 7, 1, 0, 0}, '{2, 7, 0, 0, 1},
              '{6, 7, 0, 0, 0}, '{13, 6, 1, 0, 0}, '{12, 6, 0, 0, 0}, '{5, 7, 1, 0, 0}};
      repeat (3) tick();
      chk("rst sclk", int'(bus.o_sclk), 0);
      chk("rst sdin", int'(bus.o_sdin), 0);
      chk("rst busy", int'(bus.o_busy), 0);
      chk("rst gain", int'(bus.o_gain), 4);
      chk("rst sat_hi", int'(bus.o_sat_hi), 0);
      chk("rst sat_lo", int'(bus.o_sat_lo), 0);
      i_reset = 1'b0;
      repeat (5) tick();
      chk("idle busy", int'(bus.o_busy), 0);
      chk("idle sclk", int'(bus.o_sclk), 0);
      bus.i_ready = 1'b1;
      tick();
      chk("init first sdin", int'(bus.o_sdin), 1);
      expect_frame("init", 4, 40);
      settle();
      for (int i = 0; i < 19; i++) begin
         for (int k = 0; k < 8; k++) win[k] = tbl[i].val;
         drive(0, 8, 1);
         decide_cycle(i % 2);
         if (tbl[i].frame != 0) begin
            expect_frame($sformatf("vec%0d", i), tbl[i].gain, 40);
            settle();
         end else expect_none($sformatf("vec%0d", i), tbl[i].gain);
         chk($sformatf("vec%0d sat_hi", i), int'(bus.o_sat_hi), tbl[i].hi);
         chk($sformatf("vec%0d sat_lo", i), int'(bus.o_sat_lo), tbl[i].lo);
      end
      for (int k = 0; k < 8; k++) win[k] = 15;
      drive(0, 8, 0);
      decide_cycle(0);
      chk("abort busy", int'(bus.o_busy), 1);
      repeat (28) tick();
      chk("abort sclk high", int'(bus.o_sclk), 1);
      bus.i_ready = 1'b0;
      tick();
      chk("abort sclk", int'(bus.o_sclk), 0);
      chk("abort sdin", int'(bus.o_sdin), 0);
      chk("abort busy low", int'(bus.o_busy), 0);
      chk("abort gain", int'(bus.o_gain), 7);
      repeat (3) tick();
      chk("abort frames", frames.size(), 0);
      bus.i_ready = 1'b1;
      tick();
      chk("reraise first sdin", int'(bus.o_sdin), 1);
      expect_frame("reraise", 4, 40);
      settle();
      for (int k = 0; k < 8; k++) win[k] = 9;
      drive(0, 3, 0);
      bus.i_force_valid = 1'b1;
      bus.i_force_gain = 3'd1;
      tick();
      bus.i_force_valid = 1'b0;
`ifdef AGC_FORCE_EN
      chk("force first sdin", int'(bus.o_sdin), 0);
      repeat (10) tick();
      bus.i_force_valid = 1'b1;
      bus.i_force_gain = 3'd5;
      tick();
      bus.i_force_valid = 1'b0;
      expect_frame("force", 1, 29);
      settle();
      drive(0, 2, 0);
      bus.i_force_valid = 1'b1;
      bus.i_force_gain = 3'd1;
      tick();
      bus.i_force_valid = 1'b0;
      expect_frame("force same", 1, 40);
      settle();
      mg = 1;
`else
      chk("force ignored busy", int'(bus.o_busy), 0);
      repeat (3) tick();
      chk("force ignored later", int'(bus.o_busy), 0);
      drive(3, 8, 0);
      decide_cycle(0);
      expect_none("force ignored window", 4);
      mg = 4;
`endif
      for (int w = 0; w < 30; w++) begin
         int c, s, sum, avg, eg, eh, el;
         c = int'($urandom_range(0, 15));
         sum = 0;
         for (int k = 0; k < 8; k++) begin
            s = c + int'($urandom_range(0, 6)) - 3;
            s = s < 0 ? 0 : s > 15 ? 15 : s;
            win[k] = s;
            sum += s;
         end
         avg = sum / 8;
         eg = mg;
         eh = 0;
         el = 0;
         if (avg > 12) begin
            if (mg > 0) eg = mg - 1;
            else eh = 1;
         end else if (avg < 6) begin
            if (mg < 7) eg = mg + 1;
            else el = 1;
         end
         drive(0, 8, 2);
         decide_cycle(w % 2);
         if (eg != mg) begin
            expect_frame($sformatf("rnd%0d", w), eg, 40);
            settle();
         end else expect_none($sformatf("rnd%0d", w), mg);
         chk($sformatf("rnd%0d sat_hi", w), int'(bus.o_sat_hi), eh);
         chk($sformatf("rnd%0d sat_lo", w), int'(bus.o_sat_lo), el);
         mg = eg;
      end
      bus.i_ready = 1'b0;
      tick();
      bus.i_ready = 1'b1;
      tick();
      chk("async frame start", int'(bus.o_busy), 1);
      repeat (12) tick();
      chk("async pre sclk", int'(bus.o_sclk), 1);
      #2 i_reset = 1'b1;
      #1;
      chk("async sclk", int'(bus.o_sclk), 0);
      chk("async sdin", int'(bus.o_sdin), 0);
      chk("async busy", int'(bus.o_busy), 0);
      chk("async gain", int'(bus.o_gain), 4);
      chk("async sat_hi", int'(bus.o_sat_hi), 0);
      chk("async sat_lo", int'(bus.o_sat_lo), 0);
      chk("sdin stable in high phase", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/agc_serial_ctrl.md
# agc_serial_ctrl

Automatic gain controller that sits beside the analog backend and programs its amplifier gain over the 2-wire serial config port (sclk/sdin). After the backend reports ready, it sends an initial gain frame, averages a window of 4-bit ADC codes, and steps gain up or down with hysteresis, re-serialising each new gain and discarding samples while the amplifier settles. An optional host override forces a specific gain.

## Interface
- `SCLK_DIV`, 4: i_clk cycles per sclk half-period (≥1)
- `WIN_LOG2`, 3: averaging window = 2^WIN_LOG2 valid samples (1..6)
- `HI_TH`, 12: avg strictly above → decrease gain
- `LO_TH`, 6: avg strictly below → increase gain (LO_TH < HI_TH)
- `HOLD`, 16: valid samples discarded after each gain change (≥1)
- `INIT_GAIN`, 3'd4: gain sent on first ready
- `i_clk` in 1: system clock, all logic rising-edge
- `i_reset` in 1: asynchronous, active-high reset
- `i_ready` in 1: backend ready level
- `i_adc_valid` in 1: i_adc qualifier, one sample per high cycle
- `i_adc` in 4: ADC code, unsigned
- `i_force_valid` in 1: host force-gain request, single-cycle pulse
- `i_force_gain` in 3: gain to force
- `o_sclk` out 1: serial clock to backend
- `o_sdin` out 1: serial data to backend
- `o_busy` out 1: high while a frame is shifting
- `o_gain` out 3: last fully transmitted gain
- `o_sat_hi` out 1: last decision wanted lower gain at gain 0
- `o_sat_lo` out 1: last decision wanted higher gain at gain 7

## Operation
- Reset values: o_sclk 0, o_sdin 0, o_busy 0, o_gain INIT_GAIN, o_sat_hi 0, o_sat_lo 0, accumulator/counters 0, state IDLE.
- States: IDLE, SHIFT, SETTLE, ACCUM, DECIDE.
- IDLE: wait for i_ready=1 → load INIT_GAIN into shift target → SHIFT.
- SHIFT: transmit 5-bit frame {gain[2:0], 2'b00}, MSB first → on completion o_gain ← target, → SETTLE.
- SETTLE: count HOLD valid samples, discard → ACCUM with accumulator cleared.
- ACCUM: sum 2^WIN_LOG2 valid samples into (4+WIN_LOG2)-bit sum, no overflow → DECIDE.
- DECIDE (one cycle): avg = sum >> WIN_LOG2 (truncate).
  - avg>HI_TH and gain>0 → target gain−1, → SHIFT.
  - avg<LO_TH and gain<7 → target gain+1, → SHIFT.
  - Otherwise → ACCUM, no frame sent.
  - o_sat_hi = (avg>HI_TH && gain==0); o_sat_lo = (avg<LO_TH && gain==7). Both flags update every decision.
- Force: i_force_valid accepted in SETTLE/ACCUM/DECIDE → target ← i_force_gain, discard partial window, → SHIFT. Force beats DECIDE in the same cycle. Ignored in IDLE and SHIFT (o_busy=1), with no queuing. A force equal to o_gain still sends a frame.
- i_ready falling in any state → IDLE next cycle. A frame in flight aborts: o_sclk/o_sdin driven 0, o_gain unchanged, o_busy 0. A later i_ready rise resends INIT_GAIN.

## Timing
- Bit period = 2·SCLK_DIV cycles. o_sdin changes only at bit start, then o_sclk is low for SCLK_DIV cycles and high for SCLK_DIV cycles. Data is stable SCLK_DIV cycles before and during the high phase.
- Frame = 10·SCLK_DIV cycles. o_busy rises the first SHIFT cycle and falls with the o_gain update, on the cycle the 5th high phase ends. o_sclk is 0 and o_sdin is 0 that cycle.
- IDLE→SHIFT: first sdin bit one cycle after i_ready sampled high.
- DECIDE→SHIFT: frame starts the cycle after DECIDE.
- Samples arriving in DECIDE or SHIFT are dropped.
- Reset mid-frame: outputs return to reset values asynchronously.

## Configuration
- `AGC_FORCE_EN` defined: force path active as above.
- `AGC_FORCE_EN` undefined: i_force_valid/i_force_gain ports remain and are ignored. Gain changes only via DECIDE.

## Test plan
- Reset, hold i_ready=0 → all outputs at reset values; raise i_ready (SCLK_DIV=4) → 40-cycle frame, sdin bits 1,0,0,0,0, then o_gain=4, o_busy falls.
- After settle, 8 samples of 15 → avg 15>12 → frame for gain 3, o_gain=3. Then 8 samples of 9 → no frame, gain stays 3.
- From gain 0, 8 samples of 14 → no frame, o_sat_hi=1. Next window of 9 → o_sat_hi=0.
- Samples all 2 from gain 6 → gain 7, then o_sat_lo=1 with no further frame.
- Force gain 1 mid-ACCUM → frame {001,00} starts next cycle, o_gain=1. Force during SHIFT → ignored, no second frame. With AGC_FORCE_EN undefined → force never sends a frame.
- Drop i_ready at bit 3 of a frame → o_sclk=0 next cycle, o_gain unchanged. Re-raise → full INIT_GAIN frame.
